// File: rtl/dkong_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : dkong_video_timing
// Raster timing generator: pixel clock-enable divider, H/V counters with flip
// views, registered blank/sync flags, frame counter and VBLANK interrupt pulse.
// Revision : 1.0  initial release
// ============================================================================
module dkong_video_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_W      = 10,
  parameter int H_TOTAL  = 768,
  parameter int H_BL_P   = 511,
  parameter int H_BL_W   = 767,
  parameter int H_SYNC_P = 576,
  parameter int H_SYNC_W = 640,
  parameter int V_W      = 9,
  parameter int V_FIRST  = 504,
  parameter int V_LAST   = 255,
  parameter int V_BL_P   = 239,
  parameter int V_BL_W   = 15,
  parameter int V_SYNC_P = 255,
  parameter int V_SYNC_W = 511
) (
  input  logic           I_CLK,
  input  logic           I_RST_n,
  input  logic           I_HFLIP,
  input  logic           I_VFLIP,
  output logic           O_PIX_CE,
  output logic [H_W-1:0] H_CNT,
  output logic [H_W-1:0] HF_CNT,
  output logic [V_W-1:0] V_CNT,
  output logic [V_W-2:0] VF_CNT,
  output logic           H_BLANKn,
  output logic           V_BLANKn,
  output logic           C_BLANKn,
  output logic           H_SYNCn,
  output logic           V_SYNCn,
  output logic           O_VBL_IRQ,
  output logic [7:0]     O_FRAME
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   c_h_last   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   c_h_bl_p   = H_W'(H_BL_P);
  localparam logic [H_W-1:0]   c_h_bl_w   = H_W'(H_BL_W);
  localparam logic [H_W-1:0]   c_h_sync_p = H_W'(H_SYNC_P);
  localparam logic [H_W-1:0]   c_h_sync_w = H_W'(H_SYNC_W);
  localparam logic [V_W-1:0]   c_v_first  = V_W'(V_FIRST);
  localparam logic [V_W-1:0]   c_v_last   = V_W'(V_LAST);
  localparam logic [V_W-1:0]   c_v_bl_p   = V_W'(V_BL_P);
  localparam logic [V_W-1:0]   c_v_bl_w   = V_W'(V_BL_W);
  localparam logic [V_W-1:0]   c_v_sync_p = V_W'(V_SYNC_P);
  localparam logic [V_W-1:0]   c_v_sync_w = V_W'(V_SYNC_W);

  // Parameter sanity: any illegal combination stops elaboration.
  if (CLK_DIV < 1) begin : g_chk_div
    $error("dkong_video_timing: CLK_DIV must be >= 1");
  end
  if (V_W < 2) begin : g_chk_vw
    $error("dkong_video_timing: V_W must be >= 2");
  end
  if (H_TOTAL < 2 || H_TOTAL > (1 << H_W)) begin : g_chk_htot
    $error("dkong_video_timing: H_TOTAL does not fit H_W");
  end
  if (H_BL_P >= H_TOTAL || H_BL_W >= H_TOTAL ||
      H_SYNC_P >= H_TOTAL || H_SYNC_W >= H_TOTAL) begin : g_chk_hrange
    $error("dkong_video_timing: H set/clear value >= H_TOTAL");
  end
  if (H_BL_P == H_BL_W || H_SYNC_P == H_SYNC_W) begin : g_chk_hpw
    $error("dkong_video_timing: H set and clear values must differ");
  end
  if (V_BL_P == V_BL_W || V_SYNC_P == V_SYNC_W) begin : g_chk_vpw
    $error("dkong_video_timing: V set and clear values must differ");
  end
  if (V_FIRST >= (1 << V_W) || V_LAST >= (1 << V_W) || V_BL_P >= (1 << V_W) ||
      V_BL_W >= (1 << V_W) || V_SYNC_P >= (1 << V_W) ||
      V_SYNC_W >= (1 << V_W)) begin : g_chk_vrange
    $error("dkong_video_timing: V value does not fit V_W");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_ce_q,  pix_ce_d;
  logic [H_W-1:0]   h_cnt_q,   h_cnt_d;
  logic [V_W-1:0]   v_cnt_q,   v_cnt_d;
  logic             hbl_q,     hbl_d;
  logic             hsync_q,   hsync_d;
  logic             vbl_q,     vbl_d;
  logic             vsync_q,   vsync_d;
  logic             cbl_q,     cbl_d;
  logic             irq_q,     irq_d;
  logic [7:0]       frame_q,   frame_d;

  logic w_div_wrap;
  logic w_line_adv;

  always_comb begin
    w_div_wrap = (div_cnt_q == c_div_last);
    div_cnt_d  = w_div_wrap ? '0 : div_cnt_q + 1'b1;
    pix_ce_d   = w_div_wrap;
  end

  // Every comparison below uses pre-edge values, so a set/clear takes
  // effect one pixel after the matching count.
  always_comb begin
    w_line_adv = pix_ce_q && (h_cnt_q == c_h_sync_p);

    h_cnt_d = h_cnt_q;
    hbl_d   = hbl_q;
    hsync_d = hsync_q;
    if (pix_ce_q) begin
      h_cnt_d = (h_cnt_q == c_h_last) ? '0 : h_cnt_q + 1'b1;
      if (h_cnt_q == c_h_bl_p) begin
        hbl_d = 1'b1;
      end else if (h_cnt_q == c_h_bl_w) begin
        hbl_d = 1'b0;
      end
      if (h_cnt_q == c_h_sync_p) begin
        hsync_d = 1'b1;
      end else if (h_cnt_q == c_h_sync_w) begin
        hsync_d = 1'b0;
      end
    end

    v_cnt_d = v_cnt_q;
    vbl_d   = vbl_q;
    vsync_d = vsync_q;
    if (w_line_adv) begin
      v_cnt_d = (v_cnt_q == c_v_last) ? c_v_first : v_cnt_q + 1'b1;
      if (v_cnt_q == c_v_bl_p) begin
        vbl_d = 1'b1;
      end else if (v_cnt_q == c_v_bl_w) begin
        vbl_d = 1'b0;
      end
      if (v_cnt_q == c_v_sync_p) begin
        vsync_d = 1'b1;
      end else if (v_cnt_q == c_v_sync_w) begin
        vsync_d = 1'b0;
      end
    end

    cbl_d   = hbl_d | vbl_d;
    irq_d   = w_line_adv && (v_cnt_q == c_v_bl_p) && !vbl_q;
    frame_d = irq_d ? frame_q + 8'd1 : frame_q;
  end

  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      div_cnt_q <= '0;
      pix_ce_q  <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= c_v_first;
      hbl_q     <= 1'b0;
      hsync_q   <= 1'b0;
      vbl_q     <= 1'b0;
      vsync_q   <= 1'b0;
      cbl_q     <= 1'b0;
      irq_q     <= 1'b0;
      frame_q   <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_ce_q  <= pix_ce_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hbl_q     <= hbl_d;
      hsync_q   <= hsync_d;
      vbl_q     <= vbl_d;
      vsync_q   <= vsync_d;
      cbl_q     <= cbl_d;
      irq_q     <= irq_d;
      frame_q   <= frame_d;
    end
  end

  assign O_PIX_CE  = pix_ce_q;
  assign H_CNT     = h_cnt_q;
  assign V_CNT     = v_cnt_q;
  assign HF_CNT    = h_cnt_q ^ {H_W{I_HFLIP}};
  assign VF_CNT    = v_cnt_q[V_W-2:0] ^ {(V_W-1){I_VFLIP}};
  assign H_BLANKn  = ~hbl_q;
  assign V_BLANKn  = ~vbl_q;
  assign C_BLANKn  = ~cbl_q;
  assign H_SYNCn   = ~hsync_q;
  assign V_SYNCn   = ~vsync_q;
  assign O_VBL_IRQ = irq_q;
  assign O_FRAME   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_dkong_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_dkong_video_timing
// Three timing generators under random flips and async resets, each compared
// every clock against a position-arithmetic raster model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dkong_video_timing;

  typedef struct {
    int clk_div; int hw; int htot; int hblp; int hblw; int hsp; int hsw;
    int vw; int vfirst; int vlast; int vblp; int vblw; int vsp; int vsw;
  } cfg_t;

  localparam int N_CYC = 42000;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] hflip;
  logic [2:0] vflip;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   e     [3];
  int   hold  [3];
  cfg_t cfg   [3];

  always #5 clk = ~clk;

  // DUT 0: default parameters
  logic       ce0, hbn0, vbn0, cbn0, hsn0, vsn0, irq0;
  logic [9:0] h0, hf0;
  logic [8:0] v0;
  logic [7:0] vf0, fr0;
  dkong_video_timing u_dut0 (
    .I_CLK(clk), .I_RST_n(rst_n[0]), .I_HFLIP(hflip[0]), .I_VFLIP(vflip[0]),
    .O_PIX_CE(ce0), .H_CNT(h0), .HF_CNT(hf0), .V_CNT(v0), .VF_CNT(vf0),
    .H_BLANKn(hbn0), .V_BLANKn(vbn0), .C_BLANKn(cbn0), .H_SYNCn(hsn0),
    .V_SYNCn(vsn0), .O_VBL_IRQ(irq0), .O_FRAME(fr0));

  // DUT 1: CE held high, tiny raster so the frame counter wraps
  logic       ce1, hbn1, vbn1, cbn1, hsn1, vsn1, irq1;
  logic [3:0] h1, hf1, v1;
  logic [2:0] vf1;
  logic [7:0] fr1;
  dkong_video_timing #(
    .CLK_DIV(1), .H_W(4), .H_TOTAL(12), .H_BL_P(7), .H_BL_W(11),
    .H_SYNC_P(9), .H_SYNC_W(10), .V_W(4), .V_FIRST(14), .V_LAST(9),
    .V_BL_P(7), .V_BL_W(1), .V_SYNC_P(9), .V_SYNC_W(15)
  ) u_dut1 (
    .I_CLK(clk), .I_RST_n(rst_n[1]), .I_HFLIP(hflip[1]), .I_VFLIP(vflip[1]),
    .O_PIX_CE(ce1), .H_CNT(h1), .HF_CNT(hf1), .V_CNT(v1), .VF_CNT(vf1),
    .H_BLANKn(hbn1), .V_BLANKn(vbn1), .C_BLANKn(cbn1), .H_SYNCn(hsn1),
    .V_SYNCn(vsn1), .O_VBL_IRQ(irq1), .O_FRAME(fr1));

  // DUT 2: divide-by-3, short lines, default vertical timing
  logic       ce2, hbn2, vbn2, cbn2, hsn2, vsn2, irq2;
  logic [3:0] h2, hf2;
  logic [8:0] v2;
  logic [7:0] vf2, fr2;
  dkong_video_timing #(
    .CLK_DIV(3), .H_W(4), .H_TOTAL(12), .H_BL_P(7), .H_BL_W(11),
    .H_SYNC_P(9), .H_SYNC_W(10)
  ) u_dut2 (
    .I_CLK(clk), .I_RST_n(rst_n[2]), .I_HFLIP(hflip[2]), .I_VFLIP(vflip[2]),
    .O_PIX_CE(ce2), .H_CNT(h2), .HF_CNT(hf2), .V_CNT(v2), .VF_CNT(vf2),
    .H_BLANKn(hbn2), .V_BLANKn(vbn2), .C_BLANKn(cbn2), .H_SYNCn(hsn2),
    .V_SYNCn(vsn2), .O_VBL_IRQ(irq2), .O_FRAME(fr2));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: everything derives from the pixel count since reset.
  function automatic int pixels_done(cfg_t c, int edges);
    return (edges >= 1) ? (edges - 1) / c.clk_div : 0;
  endfunction

  function automatic int lines_done(cfg_t c, int pix);
    return (pix + c.htot - 1 - c.hsp) / c.htot;
  endfunction

  function automatic int line_index(cfg_t c, int val);
    int m;
    m = 1 << c.vw;
    return (((val - c.vfirst) % m) + m) % m;
  endfunction

  // Active from step set_idx+1 to clr_idx (inclusive), cyclic, once first set.
  function automatic bit in_window(int abs_pos, int period, int set_idx, int clr_idx);
    int s, cl, pos;
    s   = (set_idx + 1) % period;
    cl  = (clr_idx + 1) % period;
    pos = abs_pos % period;
    if (abs_pos < set_idx + 1) return 1'b0;
    if (s < cl) return (pos >= s) && (pos < cl);
    return (pos >= s) || (pos < cl);
  endfunction

  task automatic check_dut(input string nm, input cfg_t c, input int edges,
                           input bit hfl, input bit vfl,
                           input logic [31:0] o_ce, input logic [31:0] o_h,
                           input logic [31:0] o_hf, input logic [31:0] o_v,
                           input logic [31:0] o_vf, input logic [31:0] o_hbn,
                           input logic [31:0] o_vbn, input logic [31:0] o_cbn,
                           input logic [31:0] o_hsn, input logic [31:0] o_vsn,
                           input logic [31:0] o_irq, input logic [31:0] o_fr);
    int pix, ln, ln_prev, flen, vrise, h, v, hmask, vmask;
    bit hb, hs, vb, vs, ce, irq;
    int frames;
    pix     = pixels_done(c, edges);
    ln      = lines_done(c, pix);
    ln_prev = lines_done(c, pixels_done(c, edges - 1));
    flen    = line_index(c, c.vlast) + 1;
    h       = pix % c.htot;
    v       = (c.vfirst + ln % flen) % (1 << c.vw);
    hmask   = (1 << c.hw) - 1;
    vmask   = (1 << (c.vw - 1)) - 1;
    hb      = in_window(pix, c.htot, c.hblp, c.hblw);
    hs      = in_window(pix, c.htot, c.hsp, c.hsw);
    vb      = in_window(ln, flen, line_index(c, c.vblp), line_index(c, c.vblw));
    vs      = in_window(ln, flen, line_index(c, c.vsp), line_index(c, c.vsw));
    ce      = (edges >= c.clk_div) && (edges % c.clk_div == 0);
    vrise   = line_index(c, c.vblp) + 1;
    irq     = (edges >= 1) && (ln != ln_prev) && (ln >= vrise) && ((ln - vrise) % flen == 0);
    frames  = (ln >= vrise) ? ((ln - vrise) / flen + 1) % 256 : 0;
    check_eq({nm, ".pix_ce"},   o_ce,  32'(ce));
    check_eq({nm, ".h_cnt"},    o_h,   32'(h));
    check_eq({nm, ".hf_cnt"},   o_hf,  32'(hfl ? (h ^ hmask) : h));
    check_eq({nm, ".v_cnt"},    o_v,   32'(v));
    check_eq({nm, ".vf_cnt"},   o_vf,  32'(vfl ? ((v & vmask) ^ vmask) : (v & vmask)));
    check_eq({nm, ".h_blankn"}, o_hbn, 32'(!hb));
    check_eq({nm, ".v_blankn"}, o_vbn, 32'(!vb));
    check_eq({nm, ".c_blankn"}, o_cbn, 32'(!(hb || vb)));
    check_eq({nm, ".h_syncn"},  o_hsn, 32'(!hs));
    check_eq({nm, ".v_syncn"},  o_vsn, 32'(!vs));
    check_eq({nm, ".vbl_irq"},  o_irq, 32'(irq));
    check_eq({nm, ".frame"},    o_fr,  32'(frames));
  endtask

  task automatic check_all();
    check_dut("d0", cfg[0], e[0], hflip[0], vflip[0], 32'(ce0), 32'(h0), 32'(hf0),
              32'(v0), 32'(vf0), 32'(hbn0), 32'(vbn0), 32'(cbn0), 32'(hsn0),
              32'(vsn0), 32'(irq0), 32'(fr0));
    check_dut("d1", cfg[1], e[1], hflip[1], vflip[1], 32'(ce1), 32'(h1), 32'(hf1),
              32'(v1), 32'(vf1), 32'(hbn1), 32'(vbn1), 32'(cbn1), 32'(hsn1),
              32'(vsn1), 32'(irq1), 32'(fr1));
    check_dut("d2", cfg[2], e[2], hflip[2], vflip[2], 32'(ce2), 32'(h2), 32'(hf2),
              32'(v2), 32'(vf2), 32'(hbn2), 32'(vbn2), 32'(cbn2), 32'(hsn2),
              32'(vsn2), 32'(irq2), 32'(fr2));
  endtask

  initial begin
    int  d2_reset_cyc;
    bit  did_mid_reset;
    bit  want;
    cfg[0] = '{clk_div: 2, hw: 10, htot: 768, hblp: 511, hblw: 767, hsp: 576, hsw: 640,
               vw: 9, vfirst: 504, vlast: 255, vblp: 239, vblw: 15, vsp: 255, vsw: 511};
    cfg[1] = '{clk_div: 1, hw: 4, htot: 12, hblp: 7, hblw: 11, hsp: 9, hsw: 10,
               vw: 4, vfirst: 14, vlast: 9, vblp: 7, vblw: 1, vsp: 9, vsw: 15};
    cfg[2] = '{clk_div: 3, hw: 4, htot: 12, hblp: 7, hblw: 11, hsp: 9, hsw: 10,
               vw: 9, vfirst: 504, vlast: 255, vblp: 239, vblw: 15, vsp: 255, vsw: 511};
    for (int k = 0; k < 3; k++) begin
      e[k]    = 0;
      hold[k] = 0;
    end
    rst_n         = 3'b000;
    hflip         = 3'b000;
    vflip         = 3'b111;
    did_mid_reset = 1'b0;
    d2_reset_cyc  = int'($urandom_range(15000, 25000));

    repeat (3) @(negedge clk);
    #1;
    check_all();
    rst_n = 3'b111;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_n[k]) e[k]++;
      end
      @(negedge clk);
      hflip = 3'($urandom);
      vflip = 3'($urandom);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n[k]) begin
          if (hold[k] == 0) rst_n[k] = 1'b1;
          else hold[k]--;
        end else begin
          want = 1'b0;
          if (k == 0) begin
            if (!did_mid_reset && cyc > 2000 &&
                pixels_done(cfg[0], e[0]) % cfg[0].htot == 300) begin
              did_mid_reset = 1'b1;
              want = 1'b1;
            end else if ($urandom_range(0, 2999) == 0) begin
              want = 1'b1;
            end
          end else if (k == 1) begin
            want = (cyc == 400);
          end else begin
            want = (cyc == d2_reset_cyc);
          end
          if (want) begin
            rst_n[k] = 1'b0;
            e[k]     = 0;
            hold[k]  = int'($urandom_range(0, 3));
          end
        end
      end
      #1;
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
